// File: rtl/ofs_pipeline_chain.sv
// ---------------------------------------------------------------------------
// ofs_pipeline_chain
//
// Chain of DEPTH full-throughput valid/ready register stages for AXI-style
// channels on the memory AXI bridge path. Each stage is a 2-entry skid buffer
// (main + skid), so the chain moves one beat per cycle with no bubbles. Every
// output, s_ready included, comes straight from a flop.
//
// Handshake: a beat moves across an interface on a rising clk edge where valid
// and ready are both high. A valid beat holds its payload until it is taken.
// Ready never depends combinationally on valid (except DEPTH=0 bypass, where
// the chain is a wire).
//
// Parameters
//   WIDTH  payload width in bits (>=1)
//   DEPTH  number of stages; 0 = combinational bypass (flush/occupancy inert)
//   OCC_W  occupancy width, derived (min 1)
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   flush      synchronous discard of every held entry (wins over any fire)
//   s_valid    upstream valid
//   s_ready    upstream ready (registered; 0 during rst)
//   s_data     upstream payload
//   m_valid    downstream valid (registered)
//   m_ready    downstream ready
//   m_data     downstream payload (registered)
//   occupancy  entries held across all stages, 0..2*DEPTH (registered)
//
// Optional feature, macro OFS_PIPELINE_CHAIN_STATS_EN:
//   stat_xfer  32-bit saturating count of m_valid & m_ready
//   stat_stall 32-bit saturating count of s_valid & ~s_ready
//   Both clear on rst only (flush leaves them alone).
//
// Per-stage state is kept in g_chain.state_q[] (enum whose encoding is
// {main_v, skid_v}) so checkers can bind to it hierarchically.
// ---------------------------------------------------------------------------
module ofs_pipeline_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int OCC_W = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [OCC_W-1:0] occupancy
`ifdef OFS_PIPELINE_CHAIN_STATS_EN
  ,
  output logic [31:0]      stat_xfer,
  output logic [31:0]      stat_stall
`endif
);

  // Encoding is {main_v, skid_v}; skid valid with main empty is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_e;

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;

    assign s_ready   = m_ready;
    assign m_valid   = s_valid;
    assign m_data    = s_data;
    assign occupancy = '0;
    // No state to clear in bypass mode.
    assign unused_bypass = ^{clk, rst, flush};
  end else begin : g_chain
    stage_state_e     state_q    [DEPTH];
    stage_state_e     state_d    [DEPTH];
    logic [WIDTH-1:0] main_q     [DEPTH];
    logic [WIDTH-1:0] main_d     [DEPTH];
    logic [WIDTH-1:0] skid_q     [DEPTH];
    logic [WIDTH-1:0] skid_d     [DEPTH];
    logic             in_ready_q [DEPTH];
    logic             in_ready_d [DEPTH];
    logic             stg_in_valid  [DEPTH];
    logic [WIDTH-1:0] stg_in_data   [DEPTH];
    logic             stg_out_ready [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Stage interconnect. Stage k is fed by stage k-1's main register and is
    // drained by stage k+1's registered ready, so there is no combinational
    // path running along the chain.
    always_comb begin
      stg_in_valid[0]        = s_valid;
      stg_in_data[0]         = s_data;
      stg_out_ready[DEPTH-1] = m_ready;
      for (int k = 1; k < DEPTH; k++) begin
        stg_in_valid[k]    = (state_q[k-1] != ST_EMPTY);
        stg_in_data[k]     = main_q[k-1];
        stg_out_ready[k-1] = in_ready_q[k];
      end
    end

    // Per-stage next state, payload moves, and the occupancy sum.
    always_comb begin
      logic in_fire;
      logic out_fire;
      occ_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
        state_d[k] = state_q[k];
        main_d[k]  = main_q[k];
        skid_d[k]  = skid_q[k];
        in_fire    = stg_in_valid[k] & in_ready_q[k];
        out_fire   = (state_q[k] != ST_EMPTY) & stg_out_ready[k];

        case (state_q[k])
          ST_EMPTY: begin
            if (in_fire) begin
              state_d[k] = ST_ONE;
              main_d[k]  = stg_in_data[k];
            end
          end
          ST_ONE: begin
            if (in_fire && !out_fire) begin
              state_d[k] = ST_FULL;
              skid_d[k]  = stg_in_data[k];
            end else if (in_fire && out_fire) begin
              main_d[k]  = stg_in_data[k];
            end else if (out_fire) begin
              state_d[k] = ST_EMPTY;
            end
          end
          ST_FULL: begin
            // in_ready is low here, so only the drain side can move.
            if (out_fire) begin
              state_d[k] = ST_ONE;
              main_d[k]  = skid_q[k];
            end
          end
          default: state_d[k] = ST_EMPTY;
        endcase

        // Flush drops everything, including a beat firing this same cycle.
        if (flush) begin
          state_d[k] = ST_EMPTY;
        end

        in_ready_d[k] = (state_d[k] != ST_FULL);
        occ_d = occ_d + OCC_W'(state_d[k] != ST_EMPTY)
                      + OCC_W'(state_d[k] == ST_FULL);
      end
    end

    // Control state: valid bits, registered ready, occupancy.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          state_q[k]    <= ST_EMPTY;
          in_ready_q[k] <= 1'b0;
        end
        occ_q <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          state_q[k]    <= state_d[k];
          in_ready_q[k] <= in_ready_d[k];
        end
        occ_q <= occ_d;
      end
    end

    // Payload registers carry no reset; they are only observed under valid.
    always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
        main_q[k] <= main_d[k];
        skid_q[k] <= skid_d[k];
      end
    end

    assign s_ready   = in_ready_q[0];
    assign m_valid   = (state_q[DEPTH-1] != ST_EMPTY);
    assign m_data    = main_q[DEPTH-1];
    assign occupancy = occ_q;
  end

`ifdef OFS_PIPELINE_CHAIN_STATS_EN
  logic [31:0] stat_xfer_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_xfer_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (m_valid && m_ready && (stat_xfer_q != 32'hFFFF_FFFF)) begin
        stat_xfer_q <= stat_xfer_q + 32'd1;
      end
      if (s_valid && !s_ready && (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_xfer  = stat_xfer_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_ofs_pipeline_chain.sv
// ---------------------------------------------------------------------------
// tb_ofs_pipeline_chain
//
// Bench for ofs_pipeline_chain. Instance u_dut is WIDTH=8 DEPTH=2; instance
// u_byp is DEPTH=0. The reference for u_dut is a FIFO of accepted beats:
// every beat taken upstream is pushed, every beat delivered downstream must
// match the head, rst/flush empty it, and occupancy must equal its depth.
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_ofs_pipeline_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int OCC_W = 3;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [OCC_W-1:0] occupancy;

  logic             b_s_valid;
  logic             b_s_ready;
  logic [WIDTH-1:0] b_s_data;
  logic             b_m_valid;
  logic             b_m_ready;
  logic [WIDTH-1:0] b_m_data;
  logic [0:0]       b_occupancy;

`ifdef OFS_PIPELINE_CHAIN_STATS_EN
  logic [31:0] a_stat_xfer;
  logic [31:0] a_stat_stall;
  logic [31:0] b_stat_xfer;
  logic [31:0] b_stat_stall;
`endif

  always #5 clk = ~clk;

  ofs_pipeline_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
`ifdef OFS_PIPELINE_CHAIN_STATS_EN
    ,
    .stat_xfer (a_stat_xfer),
    .stat_stall(a_stat_stall)
`endif
  );

  ofs_pipeline_chain #(.WIDTH(WIDTH), .DEPTH(0)) u_byp (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_valid   (b_s_valid),
    .s_ready   (b_s_ready),
    .s_data    (b_s_data),
    .m_valid   (b_m_valid),
    .m_ready   (b_m_ready),
    .m_data    (b_m_data),
    .occupancy (b_occupancy)
`ifdef OFS_PIPELINE_CHAIN_STATS_EN
    ,
    .stat_xfer (b_stat_xfer),
    .stat_stall(b_stat_stall)
`endif
  );

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  int               n_out    = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Account for the handshakes about to happen on the next rising edge,
  // advance one cycle, then compare occupancy with the reference depth.
  task automatic step_cycle();
    logic in_f;
    logic out_f;
    in_f  = s_valid && s_ready;
    out_f = m_valid && m_ready;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_f) begin
        n_out++;
        if (exp_q.size() == 0) check_eq("out_underflow", 32'(m_valid), 32'd0);
        else check_eq("m_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (in_f) exp_q.push_back(s_data);
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("occupancy", 32'(occupancy), 32'(exp_q.size()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_chain(input logic [WIDTH-1:0] base, input int cycles,
                            output int accepted);
    logic acc;
    accepted = 0;
    m_ready  = 1'b0;
    s_valid  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      s_data = base + WIDTH'(accepted);
      acc    = s_ready;
      step_cycle();
      if (acc) accepted++;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int accepted;
    int k;
    int next_beat;
    int cyc;
    logic acc;

    rst = 1'b1; flush = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_eq("rel_s_ready", 32'(s_ready), 32'd1);

    // Back-to-back 0x01..0x10 with m_ready=1: latency DEPTH, no bubbles
    for (int i = 0; i < 18; i++) begin
      s_valid = (i < 16);
      s_data  = WIDTH'(i + 1);
      m_ready = 1'b1;
      if (i < 16) check_eq("t1_s_ready", 32'(s_ready), 32'd1);
      check_eq("t1_m_valid", 32'(m_valid), 32'(i >= DEPTH));
      if (i >= DEPTH) check_eq("t1_m_data", 32'(m_data), 32'(i - 1));
      step_cycle();
    end
    s_valid = 1'b0;

    // Backpressure: exactly 2*DEPTH beats absorbed, then in-order drain
    fill_chain(8'hA0, 8, accepted);
    check_eq("t2_accepted", 32'(accepted), 32'd4);
    check_eq("t2_occupancy", 32'(occupancy), 32'd4);
    check_eq("t2_s_ready", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_valid) begin
        check_eq("t2_drain_data", 32'(m_data), 32'(8'hA0 + k));
        k++;
      end
      step_cycle();
    end
    check_eq("t2_drain_count", 32'(k), 32'd4);

    // Flush of a full chain while 0x55 is offered
    fill_chain(8'hB0, 8, accepted);
    check_eq("t4_full", 32'(occupancy), 32'd4);
    s_valid = 1'b1; s_data = 8'h55; flush = 1'b1;
    step_cycle();
    flush = 1'b0; s_valid = 1'b0;
    check_eq("t4_m_valid", 32'(m_valid), 32'd0);
    check_eq("t4_s_ready", 32'(s_ready), 32'd1);
    // Flush while a beat actually fires: the beat is discarded too
    s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b0;
    step_cycle();
    s_data = 8'h66; flush = 1'b1;
    check_eq("t4_fire_ready", 32'(s_ready), 32'd1);
    step_cycle();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_no_ghost", 32'(m_valid), 32'd0);
      step_cycle();
    end

    // Reset mid-stream with 3 entries held
    fill_chain(8'hC0, 3, accepted);
    check_eq("t5_occ3", 32'(occupancy), 32'd3);
    rst = 1'b1;
    step_cycle();
    check_eq("t5_rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("t5_rst_s_ready", 32'(s_ready), 32'd0);
    step_cycle();
    check_eq("t5_rst_s_ready2", 32'(s_ready), 32'd0);
    rst = 1'b0;
    step_cycle();
    check_eq("t5_rel_s_ready", 32'(s_ready), 32'd1);
    check_eq("t5_rel_m_valid", 32'(m_valid), 32'd0);

    // Random valid/ready, 10k incrementing beats
    n_out = 0;
    next_beat = 0;
    cyc = 0;
    while (next_beat < 10000 && cyc < 60000) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = WIDTH'(next_beat);
      acc     = s_valid && s_ready;
      step_cycle();
      if (acc) next_beat++;
      cyc++;
    end
    check_eq("t3_budget", 32'(next_beat), 32'd10000);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (10) step_cycle();
    check_eq("t3_out_count", 32'(n_out), 32'd10000);
    check_eq("t3_drained", 32'(occupancy), 32'd0);

`ifdef OFS_PIPELINE_CHAIN_STATS_EN
    // DEPTH=0 counters: 100 transfers then 7 stall cycles
    b_s_valid = 1'b1; b_m_ready = 1'b1;
    repeat (100) @(negedge clk);
    b_m_ready = 1'b0;
    repeat (7) @(negedge clk);
    b_s_valid = 1'b0;
    @(negedge clk);
    check_eq("stat_xfer", b_stat_xfer, 32'd100);
    check_eq("stat_stall", b_stat_stall, 32'd7);
`endif

    // DEPTH=0: combinational mirror
    for (int i = 0; i < 20; i++) begin
      b_s_valid = 1'($urandom_range(0, 1));
      b_m_ready = 1'($urandom_range(0, 1));
      b_s_data  = WIDTH'($urandom_range(0, 255));
      #1;
      check_eq("byp_s_ready", 32'(b_s_ready), 32'(b_m_ready));
      check_eq("byp_m_valid", 32'(b_m_valid), 32'(b_s_valid));
      check_eq("byp_m_data", 32'(b_m_data), 32'(b_s_data));
      check_eq("byp_occupancy", 32'(b_occupancy), 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
